// File: rtl/bit_destuffer.sv
// bit_destuffer: CAN receive-path bit destuffing stage.
// Tracks runs of equal sampled bits inside the stuffed region, flags the bit
// period that carries an inserted stuff bit (is_stuff), forwards destuffed
// data bits, detects stuff errors and counts removed stuff bits.
module bit_destuffer #(
  parameter int STUFF_LEN = 5,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sp,
  input  logic             rx_bit,
  input  logic             stuff_en,
  output logic             is_stuff,
  output logic             data_valid,
  output logic             data_bit,
  output logic             stuff_err,
  output logic [CNT_W-1:0] stuff_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STUFF = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam logic [2:0]       STUFF_LEN_W = 3'(STUFF_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  state_t     state;
  logic       sp_q;
  logic       sp_ev;
  logic [2:0] run_cnt;
  logic       last_bit;
  logic [2:0] run_next;

  // Rising edge of the sample-point strobe: one event per strobe, however long
  assign sp_ev = sp & ~sp_q;

  // Length the current run would have if rx_bit were accepted as a data bit
  always_comb begin
    run_next = 3'd1;
    if ((run_cnt == 3'd0) || (rx_bit != last_bit)) begin
      run_next = 3'd1;
    end else begin
      run_next = run_cnt + 3'd1;
    end
  end

  // Destuffing state machine with all outputs registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sp_q       <= 1'b0;
      is_stuff   <= 1'b0;
      data_valid <= 1'b0;
      data_bit   <= 1'b0;
      stuff_err  <= 1'b0;
      stuff_cnt  <= '0;
      run_cnt    <= 3'd0;
      last_bit   <= 1'b1;
    end else begin
      sp_q       <= sp;
      data_valid <= 1'b0;
      if (state == IDLE || !stuff_en) begin
        // Outside the stuffed region (or leaving it): plain pass-through,
        // all tracking cleared; entering the region takes effect next clk.
        is_stuff  <= 1'b0;
        stuff_err <= 1'b0;
        stuff_cnt <= '0;
        run_cnt   <= 3'd0;
        if (sp_ev) begin
          data_valid <= 1'b1;
          data_bit   <= rx_bit;
        end
        if (stuff_en) begin
          state <= RUN;
        end else begin
          state <= IDLE;
        end
      end else begin
        case (state)
          RUN: begin
            if (sp_ev) begin
              data_valid <= 1'b1;
              data_bit   <= rx_bit;
              run_cnt    <= run_next;
              last_bit   <= rx_bit;
              if (run_next == STUFF_LEN_W) begin
                state    <= STUFF;
                is_stuff <= 1'b1;
              end
            end
          end
          STUFF: begin
            if (sp_ev) begin
              is_stuff <= 1'b0;
              if (rx_bit != last_bit) begin
                // Valid stuff bit: dropped, but it opens a new run
                last_bit <= rx_bit;
                run_cnt  <= 3'd1;
                state    <= RUN;
                if (stuff_cnt != CNT_MAX) begin
                  stuff_cnt <= stuff_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
              end else begin
                stuff_err <= 1'b1;
                state     <= ERROR;
              end
            end
          end
          ERROR: begin
            // Parked until the stuffed region ends or reset
            stuff_err <= 1'b1;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bit_destuffer.sv
// Directed self-checking bench for bit_destuffer.
module tb_bit_destuffer;

  logic       clk;
  logic       reset;
  logic       sp;
  logic       rx_bit;
  logic       stuff_en;
  logic       is_stuff;
  logic       data_valid;
  logic       data_bit;
  logic       stuff_err;
  logic [7:0] stuff_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int dv_cnt = 0;

  bit_destuffer #(.STUFF_LEN(5), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .sp         (sp),
    .rx_bit     (rx_bit),
    .stuff_en   (stuff_en),
    .is_stuff   (is_stuff),
    .data_valid (data_valid),
    .data_bit   (data_bit),
    .stuff_err  (stuff_err),
    .stuff_cnt  (stuff_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count data_valid pulses (each is high for exactly one edge)
  always @(posedge clk) begin
    if (reset && data_valid === 1'b1) dv_cnt <= dv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One sample event: sp high for one clk, then low for one clk.
  // Returns with time at #1 after the event edge (outputs of the event visible).
  task automatic send(input logic b);
    rx_bit = b;
    sp     = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic gap();
    sp = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle_clks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset    = 1'b0;
    sp       = 1'b0;
    rx_bit   = 1'b1;
    stuff_en = 1'b0;
    #12;
    chk("rst_is_stuff",  32'(is_stuff),   32'd0);
    chk("rst_dv",        32'(data_valid), 32'd0);
    chk("rst_data_bit",  32'(data_bit),   32'd0);
    chk("rst_err",       32'(stuff_err),  32'd0);
    chk("rst_cnt",       32'(stuff_cnt),  32'd0);
    chk("rst_last_bit",  32'(dut.last_bit), 32'd1);
    reset = 1'b1;
    idle_clks(2);

    // Pass-through: seven zeros, no stuff checking
    dv_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      send(1'b0);
      chk("pt_dv", 32'(data_valid), 32'd1);
      chk("pt_bit", 32'(data_bit), 32'd0);
      chk("pt_is_stuff", 32'(is_stuff), 32'd0);
      gap();
    end
    chk("pt_dv_total", 32'(dv_cnt), 32'd7);
    chk("pt_cnt", 32'(stuff_cnt), 32'd0);

    // Single stuff: 0x5, stuff 1, then 1,0
    stuff_en = 1'b1;
    idle_clks(1);
    dv_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      send(1'b0); gap();
    end
    chk("ss_pre_is_stuff", 32'(is_stuff), 32'd0);
    send(1'b0);
    chk("ss_is_stuff_on", 32'(is_stuff), 32'd1);
    chk("ss_dv5", 32'(data_valid), 32'd1);
    gap();
    idle_clks(2);
    chk("ss_is_stuff_hold", 32'(is_stuff), 32'd1);
    send(1'b1);
    chk("ss_stuff_dv", 32'(data_valid), 32'd0);
    chk("ss_is_stuff_off", 32'(is_stuff), 32'd0);
    chk("ss_cnt1", 32'(stuff_cnt), 32'd1);
    gap();
    send(1'b1);
    chk("ss_bit7", 32'(data_bit), 32'd1);
    gap();
    send(1'b0);
    chk("ss_bit8", 32'(data_bit), 32'd0);
    gap();
    chk("ss_dv_total", 32'(dv_cnt), 32'd7);
    chk("ss_err", 32'(stuff_err), 32'd0);

    // Stuff bit starts a run: 1x5, stuff 0, 0x4, stuff 1
    stuff_en = 1'b0;
    idle_clks(1);
    chk("sr_cnt_clear", 32'(stuff_cnt), 32'd0);
    stuff_en = 1'b1;
    idle_clks(1);
    for (int i = 0; i < 5; i++) begin
      send(1'b1); gap();
    end
    chk("sr_is_stuff_a", 32'(is_stuff), 32'd1);
    send(1'b0); gap();
    chk("sr_cnt1", 32'(stuff_cnt), 32'd1);
    for (int i = 0; i < 3; i++) begin
      send(1'b0); gap();
    end
    chk("sr_is_stuff_3", 32'(is_stuff), 32'd0);
    send(1'b0); gap();
    chk("sr_is_stuff_4", 32'(is_stuff), 32'd1);
    send(1'b1); gap();
    chk("sr_cnt2", 32'(stuff_cnt), 32'd2);
    chk("sr_is_stuff_off", 32'(is_stuff), 32'd0);

    // Stuff error: 0x5 then 0
    stuff_en = 1'b0;
    idle_clks(1);
    stuff_en = 1'b1;
    idle_clks(1);
    for (int i = 0; i < 5; i++) begin
      send(1'b0); gap();
    end
    send(1'b0);
    chk("se_err", 32'(stuff_err), 32'd1);
    chk("se_is_stuff", 32'(is_stuff), 32'd0);
    chk("se_dv", 32'(data_valid), 32'd0);
    gap();
    send(1'b1);
    chk("se_dv_blocked", 32'(data_valid), 32'd0);
    chk("se_err_sticky", 32'(stuff_err), 32'd1);
    gap();
    stuff_en = 1'b0;
    idle_clks(1);
    chk("se_err_clear", 32'(stuff_err), 32'd0);
    send(1'b1);
    chk("se_pt_dv", 32'(data_valid), 32'd1);
    chk("se_pt_bit", 32'(data_bit), 32'd1);
    gap();

    // Long sp: held high for 4 clk -> one event
    stuff_en = 1'b1;
    idle_clks(1);
    dv_cnt = 0;
    rx_bit = 1'b1;
    sp     = 1'b1;
    idle_clks(4);
    sp = 1'b0;
    idle_clks(2);
    chk("lsp_dv_total", 32'(dv_cnt), 32'd1);
    chk("lsp_run_cnt", 32'(dut.run_cnt), 32'd1);

    // Reset mid-stuff: four more 1s make five
    for (int i = 0; i < 4; i++) begin
      send(1'b1); gap();
    end
    chk("rm_is_stuff_pre", 32'(is_stuff), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rm_is_stuff", 32'(is_stuff), 32'd0);
    chk("rm_err", 32'(stuff_err), 32'd0);
    chk("rm_cnt", 32'(stuff_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle_clks(1);
    send(1'b0);
    chk("rm_run_cnt", 32'(dut.run_cnt), 32'd1);
    chk("rm_dv", 32'(data_valid), 32'd1);
    chk("rm_bit", 32'(data_bit), 32'd0);
    gap();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
